rd_seq_arb: RTL and testbench

- Parametrised multi-channel read sequencer. Arbitrates N_CH requesters round-robin and runs a burst of 1..2^LEN_W-1 read beats for the granted channel.
- Each beat is a READ/DLY handshake against a shared wait-state input `ws`. A per-beat timeout aborts the burst with an error.
- Sits between channel request logic and a slow, wait-stated read port. All outputs are registered and glitch-free.

---
 rtl/rd_seq_arb.sv | 171 +++++++++++++++++
 tb/tb_rd_seq_arb.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rd_seq_arb.sv
// rd_seq_arb: round-robin multi-channel read sequencer.
// Grants one of N_CH requesters and runs a 1..2^LEN_W-1 beat burst of
// READ/DLY handshakes against a shared wait-state input, with a per-beat
// wait-state timeout that aborts the burst.
//
// Ports:
//   clk     - clock
//   rst_n   - asynchronous active-low reset
//   go      - per-channel request level (sampled only in IDLE)
//   len     - per-channel burst length, channel i at [i*LEN_W +: LEN_W], 0 => 1
//   ws      - wait-state from the read port, sampled only in DLY
//   rd      - read strobe (high in READ and DLY)
//   ch_sel  - granted channel index (held through the burst and in IDLE)
//   busy    - sequencer not idle
//   ds      - one-cycle done pulse to the granted channel
//   err     - one-cycle timeout pulse to the granted channel
//
// States:
//   IDLE | waiting for a request, arbitrating
//   READ | read strobe issued for the current beat
//   DLY  | read strobe held, ws sampled (complete / retry / timeout)
//   DONE | burst finished, ds pulse
//   ERR  | wait-state timeout, err pulse, remaining beats dropped
module rd_seq_arb #(
    parameter int N_CH    = 4,
    parameter int LEN_W   = 4,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_CH-1:0]               go,
    input  logic [N_CH*LEN_W-1:0]         len,
    input  logic                          ws,
    output logic                          rd,
    output logic [$clog2(N_CH)-1:0]       ch_sel,
    output logic                          busy,
    output logic [N_CH-1:0]               ds,
    output logic [N_CH-1:0]               err
);
    localparam int CH_W = $clog2(N_CH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DLY,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     rr_q, rr_d;
    logic [CH_W-1:0]     ch_sel_q, ch_sel_d;
    logic [LEN_W-1:0]    beats_q, beats_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic                rd_q, rd_d;
    logic                busy_q, busy_d;
    logic [N_CH-1:0]     ds_q, ds_d;
    logic [N_CH-1:0]     err_q, err_d;

    logic [LEN_W-1:0]    len_a [N_CH];
    logic                gnt_vld;
    logic [CH_W-1:0]     gnt_idx;
    logic [LEN_W-1:0]    gnt_len;
    logic [TO_W-1:0]     to_inc;
    logic [N_CH-1:0]     ch_onehot;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_len
        assign len_a[gi] = len[gi*LEN_W +: LEN_W];
    end

    // Scan from the farthest candidate down to the rr pointer so the last hit
    // (the first requester at or after the pointer, wrapping) wins.
    always_comb begin : arb_p
        logic [CH_W:0] sum;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            sum = {1'b0, rr_q} + (CH_W+1)'(i);
            if (sum >= (CH_W+1)'(N_CH)) begin
                sum = sum - (CH_W+1)'(N_CH);
            end
            if (go[sum[CH_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = sum[CH_W-1:0];
            end
        end
    end

    assign gnt_len = len_a[gnt_idx];
    assign to_inc  = to_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        ch_sel_d = ch_sel_q;
        beats_d  = beats_q;
        to_d     = to_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    rr_d     = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
                    ch_sel_d = gnt_idx;
                    beats_d  = (gnt_len == '0) ? LEN_W'(1) : gnt_len;
                    to_d     = '0;
                    state_d  = S_READ;
                end
            end
            S_READ: state_d = S_DLY;
            S_DLY: begin
                if (!ws) begin
                    to_d = '0;
                    if (beats_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        beats_d = beats_q - 1'b1;
                        state_d = S_READ;
                    end
                end else begin
                    to_d = to_inc;
                    state_d = (to_inc == TO_W'(TIMEOUT)) ? S_ERR : S_READ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register into place
    // in the first cycle of each state.
    always_comb begin
        ch_onehot = N_CH'(1) << ch_sel_d;
        rd_d      = (state_d == S_READ) || (state_d == S_DLY);
        busy_d    = (state_d != S_IDLE);
        ds_d      = (state_d == S_DONE) ? ch_onehot : '0;
        err_d     = (state_d == S_ERR)  ? ch_onehot : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_q     <= '0;
            ch_sel_q <= '0;
            beats_q  <= '0;
            to_q     <= '0;
            rd_q     <= 1'b0;
            busy_q   <= 1'b0;
            ds_q     <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            ch_sel_q <= ch_sel_d;
            beats_q  <= beats_d;
            to_q     <= to_d;
            rd_q     <= rd_d;
            busy_q   <= busy_d;
            ds_q     <= ds_d;
            err_q    <= err_d;
        end
    end

    assign rd     = rd_q;
    assign ch_sel = ch_sel_q;
    assign busy   = busy_q;
    assign ds     = ds_q;
    assign err    = err_q;

endmodule

// File: tb/tb_rd_seq_arb.sv
// Testbench for rd_seq_arb: directed and random bursts, reference model at
// transaction level, scoreboard of expected ds/err pulses checked by a monitor.
module tb_rd_seq_arb;
    localparam int N_CH    = 4;
    localparam int LEN_W   = 4;
    localparam int TO_W    = 8;
    localparam int TIMEOUT = 4;
    localparam int CH_W    = $clog2(N_CH);

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [N_CH-1:0]         go;
    logic [N_CH*LEN_W-1:0]   len;
    logic                    ws;
    logic                    rd;
    logic [CH_W-1:0]         ch_sel;
    logic                    busy;
    logic [N_CH-1:0]         ds;
    logic [N_CH-1:0]         err;

    rd_seq_arb #(
        .N_CH(N_CH), .LEN_W(LEN_W), .TO_W(TO_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .len(len), .ws(ws),
        .rd(rd), .ch_sel(ch_sel), .busy(busy), .ds(ds), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int rr_m   = 0;
    int last_g = 0;

    typedef struct {
        int ch;
        bit is_err;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   ws_plan [256];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every ds/err pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ds !== '0 || err !== '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: ds=%b err=%b with nothing expected (cycle %0d)", ds, err, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse_cycle", 64'(cyc), 64'(mon_e.cyc));
                    check("ds_vec",  64'(ds),  mon_e.is_err ? 64'd0 : 64'(1) << mon_e.ch);
                    check("err_vec", 64'(err), mon_e.is_err ? 64'(1) << mon_e.ch : 64'd0);
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                mon_e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_pulse: no ds/err pulse, expected ch %0d at cycle %0d (now %0d)", mon_e.ch, mon_e.cyc, cyc);
            end
        end
    end

    // Starts at a negedge while the DUT is in IDLE; returns at the negedge of
    // the IDLE cycle following the pulse, so calls may be chained back to back.
    // ws_mode: 0 random, 1 always 0, 2 always 1, 3 high on first two DLY samples.
    task automatic run_txn(input logic [N_CH-1:0] mask, input int lenv, input int ws_mode, input bit hold);
        int g, b, t, to, p;
        bit is_err;
        logic [LEN_W-1:0] lv;
        go = mask;
        for (int c = 0; c < N_CH; c++) begin
            lv = (lenv < 0) ? LEN_W'($urandom_range(0, 15)) : LEN_W'(lenv);
            len[c*LEN_W +: LEN_W] = lv;
        end
        for (int k = 0; k < 256; k++) begin
            case (ws_mode)
                0:       ws_plan[k] = ($urandom_range(0, 99) < 45);
                1:       ws_plan[k] = 1'b0;
                2:       ws_plan[k] = 1'b1;
                default: ws_plan[k] = (k == 2 || k == 4);
            endcase
        end
        ws = $urandom_range(0, 1) == 1;
        if (mask == '0) begin
            @(negedge clk);
            check("idle_no_req", {62'd0, busy, rd}, 64'd0);
            return;
        end
        g = -1;
        for (int i = 0; i < N_CH; i++) begin
            int c;
            c = (rr_m + i) % N_CH;
            if (g < 0 && mask[c]) g = c;
        end
        last_g = g;
        rr_m = (g + 1) % N_CH;
        b = int'(len[g*LEN_W +: LEN_W]);
        if (b == 0) b = 1;
        t = 0; to = 0; p = 0; is_err = 1'b0;
        while (p == 0) begin
            t += 2;
            if (!ws_plan[t]) begin
                to = 0;
                if (b == 1) p = t + 1;
                else b--;
            end else begin
                to++;
                if (to == TIMEOUT) begin
                    p = t + 1;
                    is_err = 1'b1;
                end
            end
        end
        exp_q.push_back('{g, is_err, cyc + p});
        for (int k = 1; k <= p + 1; k++) begin
            @(negedge clk);
            ws = ws_plan[k];
            if (k < p) begin
                check("busy_rd_sel", {61'd0, busy, rd, ch_sel}, {61'd0, 1'b1, 1'b1, CH_W'(g)});
                if (!hold) begin
                    go  = N_CH'($urandom);
                    len = (N_CH*LEN_W)'($urandom);
                end
            end else if (k == p) begin
                check("pulse_state", {61'd0, busy, rd, ch_sel}, {61'd0, 1'b1, 1'b0, CH_W'(g)});
                go = hold ? mask : '0;
            end else begin
                check("idle_after", {62'd0, busy, rd}, 64'd0);
            end
        end
    endtask

    initial begin
        logic [N_CH-1:0] mask;
        go = '0; len = '0; ws = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, rd, ch_sel, ds, err}, '0);
        rst_n = 1'b1;

        run_txn(4'b0001, 1, 1, 1'b0);
        run_txn(4'b0100, 3, 1, 1'b0);
        run_txn(4'b0100, 0, 1, 1'b0);
        run_txn(4'b0010, 1, 3, 1'b0);
        run_txn(4'b1000, 1, 2, 1'b0);
        run_txn(4'b1000, 2, 1, 1'b0);

        mask = 4'b1111;
        repeat (5) run_txn(mask, 1, 1, 1'b1);
        for (int i = 0; i < N_CH; i++) begin
            run_txn(mask, 1, 1, 1'b1);
            mask[last_g] = 1'b0;
        end
        run_txn(mask, 1, 1, 1'b0);

        repeat (60) begin
            run_txn(N_CH'($urandom_range(0, 15)), -1, 0, 1'b0);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        // Reset in the DLY of a 3-beat burst on channel 0 (DUT pointer -> 1).
        go = 4'b0001;
        for (int c = 0; c < N_CH; c++) len[c*LEN_W +: LEN_W] = LEN_W'(3);
        ws = 1'b0;
        repeat (4) @(negedge clk);
        go = '0;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid", {busy, rd, ch_sel, ds, err}, '0);
        rr_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(4'b0011, 2, 1, 1'b0);
        check("post_reset_grant", 64'(last_g), 64'd0);

        go = '0;
        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
